// File: rtl/mpc_isu_pkg.sv
// mpc_types: shared types and constants for the multi-port cache issue unit.
// Provides width constants, the cache op enum, the refill entry payload
// struct, a configuration struct with its build function, and a one-hot to
// index helper. No ports.
package mpc_types;

  localparam int SET_W       = 3;
  localparam int WAY_W       = 2;
  localparam int TAG_W       = 2;
  localparam int NLINE_W     = TAG_W + SET_W;
  localparam int OFF_W       = 1;
  localparam int WBUF_W      = 7;
  localparam int ROB_W       = 4;
  localparam int ROB_SIZE    = 2 ** ROB_W;
  localparam int RFBUF_SIZE  = 32;
  localparam int RFBUF_IDX_W = $clog2(RFBUF_SIZE);
  localparam int DATA_W      = 128;
  localparam int CH          = 3;
  localparam int CH_IDX_W    = $clog2(CH);
  localparam int OP_W        = 3;
  // Credit counter holds 0..ROB_SIZE inclusive, hence one extra bit.
  localparam int CRDT_W      = ROB_W + 1;

  // Codes 4-7 are reserved and behave as hits.
  typedef enum logic [OP_W-1:0] {
    CACHE_OP_RD  = 3'd0,
    CACHE_OP_WR  = 3'd1,
    CACHE_OP_RAE = 3'd2,
    CACHE_OP_WAE = 3'd3
  } cache_op_e;

  // Payload parked in a refill buffer entry while waiting for memory data.
  typedef struct packed {
    logic [NLINE_W-1:0] id;
    logic [SET_W-1:0]   set;
    logic [WAY_W-1:0]   way;
    logic [CH-1:0]      ch;
    logic [OP_W-1:0]    op;
    logic [WBUF_W-1:0]  wbuf;
  } rf_entry_t;

  typedef struct packed {
    int nline_w;
    int rob_size;
    int rfbuf_size;
    int ch;
  } mpc_cfg_t;

  function automatic mpc_cfg_t mpc_build_cfg();
    mpc_cfg_t cfg;
    cfg.nline_w    = NLINE_W;
    cfg.rob_size   = ROB_SIZE;
    cfg.rfbuf_size = RFBUF_SIZE;
    cfg.ch         = CH;
    return cfg;
  endfunction

  // Inputs are guaranteed one-hot, so OR-ing the set bit positions is exact.
  function automatic logic [CH_IDX_W-1:0] onehot_to_idx(input logic [CH-1:0] oh);
    logic [CH_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < CH; i++) begin
      idx = idx | (oh[i] ? CH_IDX_W'(i) : {CH_IDX_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/mpc_isu_if.sv
// mpc_isu_if: bundles every handshake/bus signal of the issue unit.
//   HTU request   : u_htu_valid/ready, channel, op, id, offset, wbuf, refill info
//   memctl refill : memctl_refill_valid/ready, id, data
//   xbar credits  : u_xbar_crdt_rtn[CH]
//   RC issue      : d_rc_valid/ready, channel, rob id, op, set, way, wbuf, data
//   HTU release   : u_htu_crdt_valid, u_htu_crdt_way_set
// slave = issue unit view, master = environment view.
interface mpc_isu_if;
  import mpc_types::*;

  logic                u_htu_valid;
  logic                u_htu_ready;
  logic [CH-1:0]       u_htu_channel_1hot_id;
  logic [OP_W-1:0]     u_htu_op;
  logic [NLINE_W-1:0]  u_htu_id;
  logic [OFF_W-1:0]    u_htu_offset;
  logic [WBUF_W-1:0]   u_htu_wbuf_id;
  logic                u_htu_refill_valid;
  logic [SET_W-1:0]    u_htu_refill_set;
  logic [WAY_W-1:0]    u_htu_refill_way;

  logic                memctl_refill_valid;
  logic                memctl_refill_ready;
  logic [NLINE_W-1:0]  memctl_refill_id;
  logic [DATA_W-1:0]   memctl_refill_data;

  logic [ROB_W-1:0]    u_xbar_crdt_rtn [CH];

  logic                d_rc_valid;
  logic                d_rc_ready;
  logic [CH-1:0]       d_rc_channel_1hot_id;
  logic [ROB_W-1:0]    d_rc_rob_id;
  logic [OP_W-1:0]     d_rc_op;
  logic [SET_W-1:0]    d_rc_set;
  logic [WAY_W-1:0]    d_rc_way;
  logic [WBUF_W-1:0]   d_rc_wbuf_id;
  logic [DATA_W-1:0]   d_rc_refill_data;

  logic                u_htu_crdt_valid;
  logic [NLINE_W-1:0]  u_htu_crdt_way_set;

  modport slave (
    input  u_htu_valid, u_htu_channel_1hot_id, u_htu_op, u_htu_id, u_htu_offset,
           u_htu_wbuf_id, u_htu_refill_valid, u_htu_refill_set, u_htu_refill_way,
           memctl_refill_valid, memctl_refill_id, memctl_refill_data,
           u_xbar_crdt_rtn, d_rc_ready,
    output u_htu_ready, memctl_refill_ready, d_rc_valid, d_rc_channel_1hot_id,
           d_rc_rob_id, d_rc_op, d_rc_set, d_rc_way, d_rc_wbuf_id, d_rc_refill_data,
           u_htu_crdt_valid, u_htu_crdt_way_set
  );

  modport master (
    output u_htu_valid, u_htu_channel_1hot_id, u_htu_op, u_htu_id, u_htu_offset,
           u_htu_wbuf_id, u_htu_refill_valid, u_htu_refill_set, u_htu_refill_way,
           memctl_refill_valid, memctl_refill_id, memctl_refill_data,
           u_xbar_crdt_rtn, d_rc_ready,
    input  u_htu_ready, memctl_refill_ready, d_rc_valid, d_rc_channel_1hot_id,
           d_rc_rob_id, d_rc_op, d_rc_set, d_rc_way, d_rc_wbuf_id, d_rc_refill_data,
           u_htu_crdt_valid, u_htu_crdt_way_set
  );

endinterface

// File: rtl/mpc_isu_rfbuf.sv
// mpc_isu_rfbuf: refill buffer. Holds miss-allocate requests until their line
// data arrives from memory.
//   clk, rst_n            : clock, synchronous active-high reset
//   alloc_en/alloc_entry  : park a new request in the lowest free entry
//   free_avail            : at least one entry is free
//   refill_id/refill_en/refill_data : id lookup and data write
//   refill_match          : a registered entry waits for refill_id
//   free_en/free_idx      : release an entry once it is issued
//   rdy_any/rdy_idx/rdy_entry/rdy_data : lowest-index entry holding data
module mpc_isu_rfbuf
  import mpc_types::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_en,
  input  rf_entry_t              alloc_entry,
  output logic                   free_avail,
  input  logic [NLINE_W-1:0]     refill_id,
  input  logic                   refill_en,
  input  logic [DATA_W-1:0]      refill_data,
  output logic                   refill_match,
  input  logic                   free_en,
  input  logic [RFBUF_IDX_W-1:0] free_idx,
  output logic                   rdy_any,
  output logic [RFBUF_IDX_W-1:0] rdy_idx,
  output rf_entry_t              rdy_entry,
  output logic [DATA_W-1:0]      rdy_data
);

  localparam mpc_cfg_t CFG   = mpc_build_cfg();
  localparam int       DEPTH = CFG.rfbuf_size;

  logic [DEPTH-1:0]       valid_r;
  logic [DEPTH-1:0]       dv_r;
  rf_entry_t              ent_r  [DEPTH];
  logic [DATA_W-1:0]      data_r [DEPTH];

  logic                   free_avail_s;
  logic [RFBUF_IDX_W-1:0] alloc_idx_s;
  logic                   match_s;
  logic [RFBUF_IDX_W-1:0] match_idx_s;
  logic                   rdy_any_s;
  logic [RFBUF_IDX_W-1:0] rdy_idx_s;

  // Scan entries high-to-low so the lowest matching index wins each search.
  always_comb begin
    free_avail_s = 1'b0;
    alloc_idx_s  = '0;
    match_s      = 1'b0;
    match_idx_s  = '0;
    rdy_any_s    = 1'b0;
    rdy_idx_s    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_r[i]) begin
        free_avail_s = 1'b1;
        alloc_idx_s  = RFBUF_IDX_W'(i);
      end else if (!dv_r[i]) begin
        if (ent_r[i].id == refill_id) begin
          match_s     = 1'b1;
          match_idx_s = RFBUF_IDX_W'(i);
        end else begin
          match_s     = match_s;
        end
      end else begin
        rdy_any_s = 1'b1;
        rdy_idx_s = RFBUF_IDX_W'(i);
      end
    end
  end

  // Entry state: alloc targets a free entry, free targets a data-ready entry
  // and refill targets a waiting entry, so the three never collide.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_r <= '0;
      dv_r    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_en && alloc_idx_s == RFBUF_IDX_W'(i)) begin
          valid_r[i] <= 1'b1;
          dv_r[i]    <= 1'b0;
        end else if (free_en && free_idx == RFBUF_IDX_W'(i)) begin
          valid_r[i] <= 1'b0;
          dv_r[i]    <= 1'b0;
        end else if (refill_en && match_idx_s == RFBUF_IDX_W'(i)) begin
          dv_r[i]    <= 1'b1;
        end
      end
    end
  end

  // Payload and data storage; only meaningful while the entry is valid.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      ent_r[alloc_idx_s] <= alloc_entry;
    end
    if (refill_en) begin
      data_r[match_idx_s] <= refill_data;
    end
  end

  assign free_avail   = free_avail_s;
  assign refill_match = match_s;
  assign rdy_any      = rdy_any_s;
  assign rdy_idx      = rdy_idx_s;
  assign rdy_entry    = ent_r[rdy_idx_s];
  assign rdy_data     = data_r[rdy_idx_s];

endmodule

// File: rtl/mpc_isu.sv
// mpc_isu: issue unit between the hit/tag unit and the RAM controller.
// Hits go straight to the RC output register; misses wait in the refill
// buffer for memory data. Per-channel ROB ids and credits gate every issue,
// and issued misses return a {way,set} release pulse to HTU.
//   clk   : clock
//   rst_n : synchronous reset, active high
//   bus   : mpc_isu_if.slave carrying HTU, memctl, xbar credit and RC signals
module mpc_isu
  import mpc_types::*;
(
  input logic      clk,
  input logic      rst_n,
  mpc_isu_if.slave bus
);

  logic [CRDT_W-1:0]      crdt_r     [CH];
  logic [CRDT_W:0]        crdt_sum_s [CH];
  logic [CRDT_W-1:0]      crdt_nxt_s [CH];
  logic [ROB_W-1:0]       tail_r     [CH];

  logic                   d_rc_valid_r;
  logic [CH-1:0]          d_rc_ch_r;
  logic [ROB_W-1:0]       d_rc_rob_r;
  logic [OP_W-1:0]        d_rc_op_r;
  logic [SET_W-1:0]       d_rc_set_r;
  logic [WAY_W-1:0]       d_rc_way_r;
  logic [WBUF_W-1:0]      d_rc_wbuf_r;
  logic [DATA_W-1:0]      d_rc_data_r;
  logic                   crdt_valid_r;
  logic [NLINE_W-1:0]     crdt_way_set_r;

  logic                   free_avail_s;
  logic                   refill_match_s;
  logic                   rdy_any_s;
  logic [RFBUF_IDX_W-1:0] rdy_idx_s;
  rf_entry_t              rdy_entry_s;
  logic [DATA_W-1:0]      rdy_data_s;
  rf_entry_t              alloc_entry_s;

  logic [CH_IDX_W-1:0]    hit_ch_idx_s;
  logic [CH_IDX_W-1:0]    rdy_ch_idx_s;
  logic [CH_IDX_W-1:0]    issue_ch_idx_s;
  logic                   load_en_s;
  logic                   rf_issue_s;
  logic                   hit_ok_s;
  logic                   hit_issue_s;
  logic                   issue_s;
  logic                   alloc_en_s;
  logic                   refill_en_s;
  logic                   htu_ready_s;

  logic [CH-1:0]          nxt_ch_s;
  logic [OP_W-1:0]        nxt_op_s;
  logic [SET_W-1:0]       nxt_set_s;
  logic [WAY_W-1:0]       nxt_way_s;
  logic [WBUF_W-1:0]      nxt_wbuf_s;
  logic [DATA_W-1:0]      nxt_data_s;

  logic                   unused_ok_s;

  assign hit_ch_idx_s = onehot_to_idx(bus.u_htu_channel_1hot_id);
  assign rdy_ch_idx_s = onehot_to_idx(rdy_entry_s.ch);

  // Output register accepts new content when empty or being drained.
  assign load_en_s   = !d_rc_valid_r || bus.d_rc_ready;
  // Only the lowest data-ready entry competes; while it exists hits wait.
  assign rf_issue_s  = load_en_s && rdy_any_s && (crdt_r[rdy_ch_idx_s] != '0);
  assign hit_ok_s    = load_en_s && !rdy_any_s && (crdt_r[hit_ch_idx_s] != '0);
  assign hit_issue_s = bus.u_htu_valid && !bus.u_htu_refill_valid && hit_ok_s;
  assign issue_s     = rf_issue_s || hit_issue_s;
  assign issue_ch_idx_s = rf_issue_s ? rdy_ch_idx_s : hit_ch_idx_s;

  assign alloc_en_s  = bus.u_htu_valid && bus.u_htu_refill_valid && free_avail_s;
  assign refill_en_s = bus.memctl_refill_valid && refill_match_s;

  assign alloc_entry_s = '{id:   bus.u_htu_id,
                           set:  bus.u_htu_refill_set,
                           way:  bus.u_htu_refill_way,
                           ch:   bus.u_htu_channel_1hot_id,
                           op:   bus.u_htu_op,
                           wbuf: bus.u_htu_wbuf_id};

  // HTU ready depends on request kind: misses need a free entry, hits an issue slot.
  always_comb begin
    if (bus.u_htu_refill_valid) begin
      htu_ready_s = free_avail_s;
    end else begin
      htu_ready_s = hit_ok_s;
    end
  end

  // Select payload for the output register from the winning source.
  always_comb begin
    if (rf_issue_s) begin
      nxt_ch_s   = rdy_entry_s.ch;
      nxt_op_s   = rdy_entry_s.op;
      nxt_set_s  = rdy_entry_s.set;
      nxt_way_s  = rdy_entry_s.way;
      nxt_wbuf_s = rdy_entry_s.wbuf;
      nxt_data_s = rdy_data_s;
    end else begin
      nxt_ch_s   = bus.u_htu_channel_1hot_id;
      nxt_op_s   = bus.u_htu_op;
      nxt_set_s  = bus.u_htu_refill_set;
      nxt_way_s  = bus.u_htu_refill_way;
      nxt_wbuf_s = bus.u_htu_wbuf_id;
      nxt_data_s = '0;
    end
  end

  // Next credit: add returns, subtract this cycle's issue, saturate at ROB_SIZE.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      crdt_sum_s[c] = {1'b0, crdt_r[c]}
                    + {{(CRDT_W + 1 - ROB_W){1'b0}}, bus.u_xbar_crdt_rtn[c]}
                    - ((issue_s && issue_ch_idx_s == CH_IDX_W'(c)) ? (CRDT_W + 1)'(1) : (CRDT_W + 1)'(0));
      if (crdt_sum_s[c] > (CRDT_W + 1)'(ROB_SIZE)) begin
        crdt_nxt_s[c] = CRDT_W'(ROB_SIZE);
      end else begin
        crdt_nxt_s[c] = crdt_sum_s[c][CRDT_W-1:0];
      end
    end
  end

  // Per-channel credit counters and ROB tails.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < CH; c++) begin
        crdt_r[c] <= CRDT_W'(ROB_SIZE);
        tail_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        crdt_r[c] <= crdt_nxt_s[c];
        if (issue_s && issue_ch_idx_s == CH_IDX_W'(c)) begin
          tail_r[c] <= tail_r[c] + ROB_W'(1);
        end
      end
    end
  end

  // RC output register plus the HTU release pulse, which fires on the first
  // valid cycle of an issued miss.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      d_rc_valid_r   <= 1'b0;
      d_rc_ch_r      <= '0;
      d_rc_rob_r     <= '0;
      d_rc_op_r      <= '0;
      d_rc_set_r     <= '0;
      d_rc_way_r     <= '0;
      d_rc_wbuf_r    <= '0;
      d_rc_data_r    <= '0;
      crdt_valid_r   <= 1'b0;
      crdt_way_set_r <= '0;
    end else begin
      if (load_en_s) begin
        d_rc_valid_r <= issue_s;
        if (issue_s) begin
          d_rc_ch_r   <= nxt_ch_s;
          d_rc_rob_r  <= tail_r[issue_ch_idx_s];
          d_rc_op_r   <= nxt_op_s;
          d_rc_set_r  <= nxt_set_s;
          d_rc_way_r  <= nxt_way_s;
          d_rc_wbuf_r <= nxt_wbuf_s;
          d_rc_data_r <= nxt_data_s;
        end
      end
      crdt_valid_r   <= rf_issue_s;
      crdt_way_set_r <= rf_issue_s ? NLINE_W'({rdy_entry_s.way, rdy_entry_s.set}) : '0;
    end
  end

  mpc_isu_rfbuf u_rfbuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_en     (alloc_en_s),
    .alloc_entry  (alloc_entry_s),
    .free_avail   (free_avail_s),
    .refill_id    (bus.memctl_refill_id),
    .refill_en    (refill_en_s),
    .refill_data  (bus.memctl_refill_data),
    .refill_match (refill_match_s),
    .free_en      (rf_issue_s),
    .free_idx     (rdy_idx_s),
    .rdy_any      (rdy_any_s),
    .rdy_idx      (rdy_idx_s),
    .rdy_entry    (rdy_entry_s),
    .rdy_data     (rdy_data_s)
  );

  assign bus.u_htu_ready          = htu_ready_s;
  assign bus.memctl_refill_ready  = refill_match_s;
  assign bus.d_rc_valid           = d_rc_valid_r;
  assign bus.d_rc_channel_1hot_id = d_rc_ch_r;
  assign bus.d_rc_rob_id          = d_rc_rob_r;
  assign bus.d_rc_op              = d_rc_op_r;
  assign bus.d_rc_set             = d_rc_set_r;
  assign bus.d_rc_way             = d_rc_way_r;
  assign bus.d_rc_wbuf_id         = d_rc_wbuf_r;
  assign bus.d_rc_refill_data     = d_rc_data_r;
  assign bus.u_htu_crdt_valid     = crdt_valid_r;
  assign bus.u_htu_crdt_way_set   = crdt_way_set_r;

  // Word offset is reserved; the line id travels only inside the buffer.
  assign unused_ok_s = ^{bus.u_htu_offset, rdy_entry_s.id};

endmodule

// File: tb/tb_mpc_isu.sv
module tb_mpc_isu;
  import mpc_types::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mpc_isu_if bus();

  mpc_isu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [CH-1:0]      ch;
    logic [ROB_W-1:0]   rob;
    logic [OP_W-1:0]    op;
    logic [SET_W-1:0]   set;
    logic [WAY_W-1:0]   way;
    logic [WBUF_W-1:0]  wbuf;
    logic [DATA_W-1:0]  data;
    logic               crdt;
    logic [NLINE_W-1:0] way_set;
  } exp_t;

  exp_t             sbq[$];
  int               total = 0;
  int               bad   = 0;
  logic [ROB_W-1:0] tail_m [CH];
  logic             first_cyc = 1'b1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a hit on channel idx, wait (bounded) for acceptance, record expectation.
  task automatic drive_hit(input int idx, input logic [OP_W-1:0] op, input logic [SET_W-1:0] set,
                           input logic [WAY_W-1:0] way, input logic [WBUF_W-1:0] wbuf,
                           output int waited);
    exp_t e;
    bit   ok;
    bus.u_htu_valid           = 1'b1;
    bus.u_htu_refill_valid    = 1'b0;
    bus.u_htu_channel_1hot_id = CH'(1) << idx;
    bus.u_htu_op              = op;
    bus.u_htu_refill_set      = set;
    bus.u_htu_refill_way      = way;
    bus.u_htu_wbuf_id         = wbuf;
    waited = 0;
    ok = 1'b0;
    for (int w = 0; w < 30; w++) begin
      @(negedge clk);
      if (bus.u_htu_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      chk("hit_accept_timeout", bus.u_htu_ready, 1'b1);
    end else begin
      @(posedge clk);
      e.ch = CH'(1) << idx; e.rob = tail_m[idx]; e.op = op; e.set = set; e.way = way;
      e.wbuf = wbuf; e.data = '0; e.crdt = 1'b0; e.way_set = '0;
      tail_m[idx] = tail_m[idx] + 4'd1;
      sbq.push_back(e);
      #1;
    end
  endtask

  // Scoreboard monitor: compare every RC transfer against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (bus.d_rc_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rc_output", bus.d_rc_valid, 1'b0);
      end else begin
        e = sbq[0];
        if (first_cyc) begin
          chk("crdt_valid", bus.u_htu_crdt_valid, e.crdt);
          if (e.crdt) chk("crdt_way_set", bus.u_htu_crdt_way_set, e.way_set);
        end
        if (bus.d_rc_ready === 1'b1) begin
          void'(sbq.pop_front());
          chk("rc_ch", bus.d_rc_channel_1hot_id, e.ch);
          chk("rc_rob", bus.d_rc_rob_id, e.rob);
          chk("rc_op", bus.d_rc_op, e.op);
          chk("rc_set", bus.d_rc_set, e.set);
          chk("rc_way", bus.d_rc_way, e.way);
          chk("rc_wbuf", bus.d_rc_wbuf_id, e.wbuf);
          chk("rc_data", bus.d_rc_refill_data, e.data);
        end
      end
    end
    first_cyc = !(bus.d_rc_valid === 1'b1 && bus.d_rc_ready !== 1'b1);
  end

  initial begin
    int   waited;
    exp_t e;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    d0 = 128'hffff_eeee_ffff_eeee;
    d1 = 128'h1234_5678_9abc_def0_0f1e_2d3c_4b5a_6978;

    for (int c = 0; c < CH; c++) begin
      tail_m[c] = 4'd0;
      bus.u_xbar_crdt_rtn[c] = 4'd0;
    end
    bus.u_htu_valid = 1'b0; bus.u_htu_channel_1hot_id = 3'b001; bus.u_htu_op = 3'd0;
    bus.u_htu_id = 5'd0; bus.u_htu_offset = 1'b0; bus.u_htu_wbuf_id = 7'd0;
    bus.u_htu_refill_valid = 1'b0; bus.u_htu_refill_set = 3'd0; bus.u_htu_refill_way = 2'd0;
    bus.memctl_refill_valid = 1'b0; bus.memctl_refill_id = 5'd0; bus.memctl_refill_data = '0;
    bus.d_rc_ready = 1'b1;

    // Reset
    rst_n = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_d_rc_valid", bus.d_rc_valid, 1'b0);
    chk("rst_refill_ready", bus.memctl_refill_ready, 1'b0);
    chk("rst_crdt_valid", bus.u_htu_crdt_valid, 1'b0);
    chk("rst_hit_ready", bus.u_htu_ready, 1'b1);
    bus.u_htu_refill_valid = 1'b1;
    #1;
    chk("rst_miss_ready", bus.u_htu_ready, 1'b1);
    bus.u_htu_refill_valid = 1'b0;
    tick();

    // Miss WAE on channel 1hot 2, id {3,5}
    bus.u_htu_valid = 1'b1; bus.u_htu_refill_valid = 1'b1;
    bus.u_htu_channel_1hot_id = 3'b010; bus.u_htu_op = 3'(CACHE_OP_WAE);
    bus.u_htu_id = 5'd29; bus.u_htu_wbuf_id = 7'd7;
    bus.u_htu_refill_set = 3'd5; bus.u_htu_refill_way = 2'd3;
    bus.memctl_refill_id = 5'd29;
    @(negedge clk);
    chk("miss_accept_ready", bus.u_htu_ready, 1'b1);
    chk("same_cycle_no_match", bus.memctl_refill_ready, 1'b0);
    tick();
    bus.u_htu_valid = 1'b0; bus.u_htu_refill_valid = 1'b0;
    bus.memctl_refill_valid = 1'b1; bus.memctl_refill_id = 5'd0; bus.memctl_refill_data = d1;
    @(negedge clk);
    chk("nonmatch_refill_held", bus.memctl_refill_ready, 1'b0);
    tick();
    bus.memctl_refill_id = 5'd29; bus.memctl_refill_data = d0;
    @(negedge clk);
    chk("match_refill_ready", bus.memctl_refill_ready, 1'b1);
    @(posedge clk);
    e.ch = 3'b010; e.rob = tail_m[1]; e.op = 3'(CACHE_OP_WAE); e.set = 3'd5; e.way = 2'd3;
    e.wbuf = 7'd7; e.data = d0; e.crdt = 1'b1; e.way_set = 5'd29;
    tail_m[1] = tail_m[1] + 4'd1;
    sbq.push_back(e);
    #1;
    bus.memctl_refill_valid = 1'b0;
    @(negedge clk);
    chk("refill_lat_t1", bus.d_rc_valid, 1'b0);
    @(negedge clk);
    chk("refill_lat_t2", bus.d_rc_valid, 1'b1);
    chk("refill_crdt_pulse", bus.u_htu_crdt_valid, 1'b1);
    chk("refill_crdt_way_set", bus.u_htu_crdt_way_set, 5'd29);
    tick();

    // Three back-to-back RD hits on channel 1hot 1
    for (int i = 0; i < 3; i++) begin
      drive_hit(0, 3'(CACHE_OP_RD), 3'(i), 2'(i), 7'(10 + i), waited);
      chk("b2b_no_wait", 32'(waited), 32'd0);
    end
    bus.u_htu_valid = 1'b0;
    tick();

    // Credit exhaustion on channel 1hot 4
    for (int i = 0; i < ROB_SIZE; i++) begin
      drive_hit(2, 3'(CACHE_OP_WR), 3'(i), 2'(i), 7'(40 + i), waited);
    end
    chk("exhaust_last_no_wait", 32'(waited), 32'd0);
    @(negedge clk);
    chk("credit_exhausted", bus.u_htu_ready, 1'b0);
    tick();
    bus.u_xbar_crdt_rtn[2] = 4'd1;
    @(negedge clk);
    chk("credit_rtn_cycle", bus.u_htu_ready, 1'b0);
    tick();
    bus.u_xbar_crdt_rtn[2] = 4'd0;
    drive_hit(2, 3'(CACHE_OP_WR), 3'd7, 2'd1, 7'd99, waited);
    chk("credit_back_no_wait", 32'(waited), 32'd0);
    @(negedge clk);
    chk("credit_one_used", bus.u_htu_ready, 1'b0);
    bus.u_htu_valid = 1'b0;
    tick();

    // Back-pressure: hold d_rc_ready low for 5 cycles
    drive_hit(0, 3'(CACHE_OP_RD), 3'd1, 2'd2, 7'd20, waited);
    e = sbq[sbq.size() - 1];
    bus.d_rc_ready = 1'b0;
    bus.u_htu_op = 3'(CACHE_OP_WR); bus.u_htu_refill_set = 3'd3;
    bus.u_htu_refill_way = 2'd1; bus.u_htu_wbuf_id = 7'd21;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.d_rc_valid, 1'b1);
      chk("stall_rob", bus.d_rc_rob_id, e.rob);
      chk("stall_ch", bus.d_rc_channel_1hot_id, e.ch);
      chk("stall_set", bus.d_rc_set, e.set);
      chk("stall_wbuf", bus.d_rc_wbuf_id, e.wbuf);
      chk("stall_no_accept", bus.u_htu_ready, 1'b0);
      tick();
    end
    bus.d_rc_ready = 1'b1;
    drive_hit(0, 3'(CACHE_OP_WR), 3'd3, 2'd1, 7'd21, waited);
    chk("stall_release_accept", 32'(waited), 32'd0);
    bus.u_htu_valid = 1'b0;
    tick();

    // Refill entry ready while a hit is presented: refill first
    bus.u_htu_valid = 1'b1; bus.u_htu_refill_valid = 1'b1;
    bus.u_htu_channel_1hot_id = 3'b001; bus.u_htu_op = 3'(CACHE_OP_RAE);
    bus.u_htu_id = 5'd10; bus.u_htu_wbuf_id = 7'd9;
    bus.u_htu_refill_set = 3'd2; bus.u_htu_refill_way = 2'd1;
    @(negedge clk);
    chk("prio_miss_ready", bus.u_htu_ready, 1'b1);
    tick();
    bus.u_htu_valid = 1'b0; bus.u_htu_refill_valid = 1'b0;
    bus.memctl_refill_valid = 1'b1; bus.memctl_refill_id = 5'd10; bus.memctl_refill_data = d1;
    @(negedge clk);
    chk("prio_refill_ready", bus.memctl_refill_ready, 1'b1);
    @(posedge clk);
    e.ch = 3'b001; e.rob = tail_m[0]; e.op = 3'(CACHE_OP_RAE); e.set = 3'd2; e.way = 2'd1;
    e.wbuf = 7'd9; e.data = d1; e.crdt = 1'b1; e.way_set = 5'd10;
    tail_m[0] = tail_m[0] + 4'd1;
    sbq.push_back(e);
    #1;
    bus.memctl_refill_valid = 1'b0;
    bus.u_htu_valid = 1'b1; bus.u_htu_refill_valid = 1'b0;
    bus.u_htu_op = 3'(CACHE_OP_RD); bus.u_htu_refill_set = 3'd6;
    bus.u_htu_refill_way = 2'd2; bus.u_htu_wbuf_id = 7'd30;
    @(negedge clk);
    chk("prio_hit_held", bus.u_htu_ready, 1'b0);
    tick();
    drive_hit(0, 3'(CACHE_OP_RD), 3'd6, 2'd2, 7'd30, waited);
    chk("prio_hit_next_cycle", 32'(waited), 32'd0);
    bus.u_htu_valid = 1'b0;

    // Drain the scoreboard
    for (int i = 0; i < 40; i++) begin
      if (sbq.size() == 0) break;
      tick();
    end
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpc_isu.md
Name: mpc_isu

Overview:
- Issue unit of the multi-port cache, placed between the hit/tag unit (HTU) and the RAM controller (RC).
- Issues hit requests directly to RC.
- Parks miss-allocate requests in a refill buffer until memory refill data arrives, then issues them to RC together with the data.
- Manages per-channel ROB ids and credits. Returns set/way release credits to HTU.

Parameters:
- SET_W, 3, set index width
- WAY_W, 2, way index width
- TAG_W, 2, tag width; NLINE_W = TAG_W+SET_W
- OFF_W, 1, word offset width
- WBUF_W, 7, write-buffer id width
- ROB_W, 4, ROB id width; ROB_SIZE = 2**ROB_W = 16
- RFBUF_SIZE, 32, refill buffer entries
- DATA_W, 128, refill data width
- CH, 3, number of channels

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-high (asserted at 1)
- u_htu_valid/u_htu_ready  in/out  1  HTU request handshake
- u_htu_channel_1hot_id  in  CH  one-hot source channel
- u_htu_op  in  3  cache op
- u_htu_id  in  NLINE_W  {tag,set} line id
- u_htu_offset  in  OFF_W  word offset; unused, reserved
- u_htu_wbuf_id  in  WBUF_W  write-buffer id
- u_htu_refill_valid  in  1  request is a miss allocation
- u_htu_refill_set/u_htu_refill_way  in  SET_W/WAY_W  target set/way (hit or victim), sampled with u_htu_valid
- memctl_refill_valid/memctl_refill_ready  in/out  1  refill handshake
- memctl_refill_id  in  NLINE_W  refilled line id
- memctl_refill_data  in  DATA_W  refill data
- u_xbar_crdt_rtn[CH]  in  ROB_W each  credits returned per channel this cycle
- d_rc_valid/d_rc_ready  out/in  1  RC handshake
- d_rc_channel_1hot_id  out  CH; d_rc_rob_id out ROB_W; d_rc_op out 3
- d_rc_set/d_rc_way/d_rc_wbuf_id  out  SET_W/WAY_W/WBUF_W
- d_rc_refill_data  out  DATA_W  zero for hits
- u_htu_crdt_valid  out  1  one-cycle set/way release pulse
- u_htu_crdt_way_set  out  NLINE_W  {way,set} zero-extended

Behaviour:
- Ops (package enum): RD=0 read hit, WR=1 write hit, RAE=2 read miss-allocate, WAE=3 write miss-allocate; 4-7 reserved, treated as hit.
- A request is a miss iff u_htu_refill_valid=1.
- Reset: all outputs 0; refill entries invalid; per-channel credit counters = ROB_SIZE; per-channel ROB tail = 0.
- Output register: single stage holding d_rc_*. It loads when empty or when d_rc_ready=1. While d_rc_valid=1 and d_rc_ready=0, all d_rc_* hold stable.
- Source priority when loading the output register: lowest-index data-ready refill entry, then the incoming hit.
- A source issues only if its channel credit is greater than 0.
- On issue:
  - d_rc_rob_id = channel tail; tail increments and wraps at ROB_SIZE.
  - Channel credit decrements by 1.
- Each cycle, credit[c] += u_xbar_crdt_rtn[c]; the counter is ROB_W+1 bits and saturates at ROB_SIZE.
- Hit: u_htu_ready = output register loadable AND no data-ready refill entry AND credit[ch]>0 (combinational on inputs). Accepted at cycle T, d_rc_valid at T+1.
- Miss: u_htu_ready = a free entry exists. On accept, the entry stores id, set, way, channel, op, wbuf; data_valid=0. Duplicate ids are excluded by HTU; this block performs no check.
- Refill match:
  - memctl_refill_ready = 1 iff a valid registered entry has the same id and data_valid=0.
  - A non-matching refill is held (ready=0); an entry allocated in the same cycle matches from the next cycle.
  - Accepted at T: data and data_valid written at the T edge. The entry is loaded into the output register at T+1 when it wins arbitration; d_rc_valid at T+2 with the original op and refill data.
- The entry frees on load. u_htu_crdt_valid pulses for one cycle coincident with the first d_rc_valid cycle of that request, with way_set={way,set}.
- Channel index = position of the one-hot bit; inputs are guaranteed one-hot.

Decomposition:
- Package mpc_types: cache op enum (CACHE_OP_RD/WR/RAE/WAE), width constants, config struct with its build function.
- Sub-module mpc_isu_rfbuf: refill buffer entries, allocation, id match, data-ready select.

Test Plan:
- Reset: after rst_n=1 is released → d_rc_valid=0, memctl_refill_ready=0, u_htu_ready=1 for a hit; u_htu_ready=1 for a miss.
- Miss WAE: ch 1hot 2, id {3,5}, wbuf 7, refill set 5, way 3; next cycle memctl refill id {3,5}, data 0xffff_eeee_ffff_eeee, with ready=1.
  - Two cycles later: d_rc ch 2, rob 0, op WAE, set 5, way 3, wbuf 7, that data.
  - Same cycle: u_htu_crdt_valid=1, way_set=29.
- Three back-to-back RD hits on ch 1hot 1 → d_rc_rob_id 0,1,2 on consecutive cycles, refill_data 0.
- Credit exhaustion: 16 hits on ch 1hot 4 with no return → 17th sees u_htu_ready=0; return 1 via u_xbar_crdt_rtn[2] → accepted next cycle with rob_id 0.
- d_rc_ready=0 for 5 cycles with d_rc_valid=1 → outputs stable and no new acceptances; transfer completes on release.
- Refill entry data-ready while a hit is presented → refill issued first, hit held (ready=0) and issued the next cycle.
